// File: rtl/eeg_p300_pkg.sv
// Shared types and default tuning for the P300 detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eeg_p300_pkg;

  // Detector phases; WAIT_BASE is the refractory state entered after a timeout.
  typedef enum logic [2:0] {
    IDLE,
    RISING,
    PEAK,
    FALLING,
    WAIT_BASE
  } state_t;

  // Default thresholds (unsigned 8-bit sample units) and phase windows (cycles).
  localparam int unsigned BASE_TH_DEF      = 52;
  localparam int unsigned RISE_TH_DEF      = 53;
  localparam int unsigned PEAK_TH_DEF      = 70;
  localparam int unsigned RISE_TIMEOUT_DEF = 250;
  localparam int unsigned FALL_TIMEOUT_DEF = 250;
  localparam int unsigned CNT_W_DEF        = 9;

endpackage

// File: rtl/eeg_window_timer.sv
// Phase window counter: clear / enable / saturating count, flags the last cycle of the window.
// Latency: count updates on the clock edge; expired is combinational from the count.
// Backpressure: none; controlled every cycle by the owning FSM.
module eeg_window_timer #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;

  // Count up while enabled, hold at all-ones instead of wrapping; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == (i_limit - 1'b1));

endmodule

// File: rtl/eeg_fsm_p300.sv
// Streaming P300 detector: baseline -> rise -> peak -> fall -> baseline sets a sticky flag.
// Latency: detected rises on the edge that samples the returning baseline (1 cycle after it is presented).
// Backpressure: none; one sample is consumed every clock.
module eeg_fsm_p300
  import eeg_p300_pkg::*;
#(
  parameter int unsigned BASE_TH      = BASE_TH_DEF,
  parameter int unsigned RISE_TH      = RISE_TH_DEF,
  parameter int unsigned PEAK_TH      = PEAK_TH_DEF,
  parameter int unsigned RISE_TIMEOUT = RISE_TIMEOUT_DEF,
  parameter int unsigned FALL_TIMEOUT = FALL_TIMEOUT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] eeg_signal,
  output logic       detected
);

  localparam logic [7:0]       LP_BASE_TH  = 8'(BASE_TH);
  localparam logic [7:0]       LP_RISE_TH  = 8'(RISE_TH);
  localparam logic [7:0]       LP_PEAK_TH  = 8'(PEAK_TH);
  localparam logic [CNT_W-1:0] LP_RISE_LIM = CNT_W'(RISE_TIMEOUT);
  localparam logic [CNT_W-1:0] LP_FALL_LIM = CNT_W'(FALL_TIMEOUT);

  state_t           r_state;
  logic             r_detected;

  logic             w_base;
  logic             w_rise;
  logic             w_peak;
  logic             w_expired;
  logic             w_cnt_en;
  logic             w_cnt_clr;
  logic [CNT_W-1:0] w_limit;

  assign w_base = (eeg_signal <= LP_BASE_TH);
  assign w_rise = (eeg_signal >= LP_RISE_TH);
  assign w_peak = (eeg_signal >= LP_PEAK_TH);

  // The counter only advances on a RISING/FALLING self-loop; every other
  // outcome (including self-loops in states that have no window) clears it,
  // so each timed phase starts counting from zero.
  assign w_limit   = (r_state == FALLING) ? LP_FALL_LIM : LP_RISE_LIM;
  assign w_cnt_en  = ((r_state == RISING) || (r_state == FALLING)) &&
                     !w_peak && !w_base && !w_expired;
  assign w_cnt_clr = !w_cnt_en;

  eeg_window_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .i_limit   (w_limit),
    .o_expired (w_expired)
  );

  // Pattern FSM with the sticky detect flag; branch order is the per-state priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_detected <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state    <= RISING;
            r_detected <= 1'b0;
          end
        end
        RISING: begin
          if (w_peak)         r_state <= PEAK;
          else if (w_base)    r_state <= IDLE;
          else if (w_expired) r_state <= WAIT_BASE;
        end
        PEAK: begin
          if (w_peak)      r_state <= PEAK;
          else if (w_base) r_state <= IDLE;
          else             r_state <= FALLING;
        end
        FALLING: begin
          if (w_base) begin
            r_state    <= IDLE;
            r_detected <= 1'b1;
          end else if (w_peak) begin
            r_state <= PEAK;
          end else if (w_expired) begin
            r_state <= WAIT_BASE;
          end
        end
        WAIT_BASE: begin
          if (w_base) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign detected = r_detected;

endmodule

// File: tb/tb_eeg_fsm_p300.sv
// Directed bench for eeg_fsm_p300 with an expected-value queue per sample.
// Latency: each sample's expected state/flag is checked 1 ns after the edge that consumes it.
// Backpressure: n/a.
module tb_eeg_fsm_p300;
  import eeg_p300_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] eeg_signal;
  logic       detected;

  always #5 clk = ~clk;

  eeg_fsm_p300 dut (
    .clk        (clk),
    .reset      (reset),
    .eeg_signal (eeg_signal),
    .detected   (detected)
  );

  typedef struct {
    logic   det;
    state_t st;
    string  tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Drive one sample per cycle for n cycles; expectation is queued with the
  // stimulus and popped once the DUT has consumed that sample.
  task automatic run(input logic rst, input logic [7:0] s, input int n,
                     input logic det, input state_t st, input string tag);
    exp_t e;
    exp_t got;
    for (int i = 0; i < n; i++) begin
      reset      = rst;
      eeg_signal = s;
      e.det = det;
      e.st  = st;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      tests++;
      assert (detected === got.det) else begin
        fails++;
        $error("FAIL %s[%0d] detected: observed %0b expected %0b", got.tag, i, detected, got.det);
      end
      tests++;
      assert (dut.r_state === got.st) else begin
        fails++;
        $error("FAIL %s[%0d] state: observed %0d expected %0d", got.tag, i, dut.r_state, got.st);
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    eeg_signal = 8'd50;

    // Reset and release.
    run(1'b0, 8'd50,   5, 1'b0, IDLE,      "reset_hold");
    run(1'b1, 8'd50,   3, 1'b0, IDLE,      "reset_release");

    // Rise timeout: 250 cycles in RISING, then refractory ignores the peak.
    run(1'b1, 8'd55, 250, 1'b0, RISING,    "to_rising");
    run(1'b1, 8'd55,  25, 1'b0, WAIT_BASE, "to_wait");
    run(1'b1, 8'd75,  10, 1'b0, WAIT_BASE, "to_late_peak");
    run(1'b1, 8'd65,  10, 1'b0, WAIT_BASE, "to_mid");
    run(1'b1, 8'd51,  10, 1'b0, IDLE,      "to_base");

    // Rise without peak aborts.
    run(1'b1, 8'd55,  10, 1'b0, RISING,    "nfp_rise");
    run(1'b1, 8'd60,  10, 1'b0, RISING,    "nfp_60");
    run(1'b1, 8'd50,  10, 1'b0, IDLE,      "nfp_base");

    // Valid pattern, sticky flag, cleared by next rise.
    run(1'b1, 8'd55,  10, 1'b0, RISING,    "ok_rise");
    run(1'b1, 8'd75,  10, 1'b0, PEAK,      "ok_peak");
    run(1'b1, 8'd59,  10, 1'b0, FALLING,   "ok_fall");
    run(1'b1, 8'd50,  10, 1'b1, IDLE,      "ok_detect");
    run(1'b1, 8'd55,   1, 1'b0, RISING,    "ok_clear");
    run(1'b1, 8'd50,   1, 1'b0, IDLE,      "ok_abort");

    // Threshold boundaries: 52 baseline, 53 rise, 69 not a peak, 70 peak.
    run(1'b1, 8'd52,   3, 1'b0, IDLE,      "bd_52_idle");
    run(1'b1, 8'd53,   1, 1'b0, RISING,    "bd_53_rise");
    run(1'b1, 8'd69,   2, 1'b0, RISING,    "bd_69_rising");
    run(1'b1, 8'd70,   1, 1'b0, PEAK,      "bd_70_peak");
    run(1'b1, 8'd69,   1, 1'b0, FALLING,   "bd_69_fall");
    run(1'b1, 8'd52,   1, 1'b1, IDLE,      "bd_52_detect");

    // Peak on the last RISING cycle is accepted.
    run(1'b1, 8'd53,   1, 1'b0, RISING,    "w249_enter");
    run(1'b1, 8'd55, 249, 1'b0, RISING,    "w249_hold");
    run(1'b1, 8'd70,   1, 1'b0, PEAK,      "w249_peak");
    run(1'b1, 8'd60,   1, 1'b0, FALLING,   "w249_fall");
    run(1'b1, 8'd50,   1, 1'b1, IDLE,      "w249_detect");

    // One cycle later the window has closed and the peak is ignored.
    run(1'b1, 8'd53,   1, 1'b0, RISING,    "w250_enter");
    run(1'b1, 8'd55, 249, 1'b0, RISING,    "w250_hold");
    run(1'b1, 8'd55,   1, 1'b0, WAIT_BASE, "w250_timeout");
    run(1'b1, 8'd70,   3, 1'b0, WAIT_BASE, "w250_peak_ign");
    run(1'b1, 8'd60,   1, 1'b0, WAIT_BASE, "w250_mid");
    run(1'b1, 8'd50,   1, 1'b0, IDLE,      "w250_base");

    // Reset in FALLING wins; the following baseline yields no detection.
    run(1'b1, 8'd55,   1, 1'b0, RISING,    "mr_rise");
    run(1'b1, 8'd75,   1, 1'b0, PEAK,      "mr_peak");
    run(1'b1, 8'd59,   1, 1'b0, FALLING,   "mr_fall");
    run(1'b0, 8'd59,   1, 1'b0, IDLE,      "mr_reset");
    run(1'b1, 8'd50,   5, 1'b0, IDLE,      "mr_base");

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eeg_fsm_p300.md
Name: eeg_fsm_p300

Overview:
Streaming P300 event-related-potential detector for one 8-bit EEG sample channel, one sample per clock.
A finite state machine tracks the pattern baseline -> rise -> peak -> fall -> baseline, with a bounded time window on the rise and fall phases.
On a complete valid pattern it asserts a sticky `detected` flag.
It sits after the sample front-end (ADC/filter) and feeds the event-classification logic.

Parameters:
- BASE_TH, 52: sample <= BASE_TH is baseline.
- RISE_TH, 53: sample >= RISE_TH while idle starts a candidate (rising phase).
- PEAK_TH, 70: sample >= PEAK_TH is a valid peak.
- RISE_TIMEOUT, 250: maximum cycles spent in RISING before a peak must appear.
- FALL_TIMEOUT, 250: maximum cycles spent in FALLING before baseline must return.
- CNT_W, 9: width of the window counter; must satisfy 2**CNT_W > max(RISE_TIMEOUT, FALL_TIMEOUT).

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-low reset (0 = reset). Sampled on the rising edge of clk.
- eeg_signal, input, 8: unsigned EEG sample, valid every cycle.
- detected, output, 1: registered; high after a valid P300 pattern completes.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state = IDLE, counter = 0, detected = 0.
  - Reset has priority over every other event, including mid-pattern.
- States: IDLE, RISING, PEAK, FALLING, WAIT_BASE. All comparisons are unsigned, on the current sample, and take effect at the next edge.
- IDLE:
  - sample >= RISE_TH -> RISING, counter = 0, detected cleared to 0 (a new epoch starts).
  - Otherwise stay; detected holds.
- RISING:
  - sample >= PEAK_TH -> PEAK.
  - Else sample <= BASE_TH -> IDLE (aborted, no detection).
  - Else if counter == RISE_TIMEOUT-1 -> WAIT_BASE (timeout).
  - Else counter += 1.
- PEAK:
  - sample >= PEAK_TH -> stay; no time limit.
  - Else sample <= BASE_TH -> IDLE, no detection; a valid pattern must pass through FALLING.
  - Else -> FALLING, counter = 0.
- FALLING:
  - sample <= BASE_TH -> IDLE and detected = 1 on the same edge.
  - Else sample >= PEAK_TH -> PEAK (re-peak is allowed).
  - Else if counter == FALL_TIMEOUT-1 -> WAIT_BASE.
  - Else counter += 1.
- WAIT_BASE:
  - Refractory state; all samples are ignored, including peaks.
  - sample <= BASE_TH -> IDLE. detected stays 0.
- Counter behaviour:
  - Saturates and never wraps.
  - Cleared on every state entry other than a self-loop.
- `detected` timing:
  - Asserts 1 cycle after the baseline sample is presented in FALLING.
  - Remains high until the next IDLE->RISING transition or reset.
- Simultaneous conditions are resolved by the priority order listed per state above.
- A timeout must never lead to detection. After a timeout, a late peak must not be accepted until the signal has returned to baseline.

Decomposition:
- Package `eeg_p300_pkg`:
  - state enum: IDLE, RISING, PEAK, FALLING, WAIT_BASE.
  - default threshold and timeout constants.
- Natural sub-module `eeg_window_timer`:
  - clear/enable/saturating counter.
  - `expired` output, high when count == limit-1.
  - Instantiated once, with the limit muxed by state.
- Everything else lives in the top-level FSM.

Test Plan:
- Reset: hold reset=0 for 5 cycles with sample=50 -> detected=0, state IDLE. Release (reset=1) with sample=50 -> detected remains 0.
- Timeout: sample 55 for 275 cycles, then 75 for 10, 65 for 10, 51 for 10 -> WAIT_BASE is entered at cycle 250. The 75 is ignored and detected stays 0 throughout.
- No false positive: 55 for 10 cycles, 60 for 10, 50 for 10 -> returns to IDLE and detected stays 0.
- Valid P300: 55 for 10, 75 for 10, 59 for 10, 50 for 10 -> detected=1 one cycle after the first 50 and still 1 ten cycles later. A subsequent 55 clears it.
- Boundaries: exactly 52 counts as baseline, 53 starts a rise, 69 is not a peak, 70 is a peak. A peak on cycle 249 of RISING is accepted; on cycle 250 it is rejected.
- Mid-pattern reset: apply reset=0 while in FALLING with sample 59 -> IDLE, detected=0. Following 50 samples produce no detection.
